// File: rtl/csr_cntr_file.sv
// csr_cntr_file: machine counter CSR storage (mcycle, minstret, mcountinhibit
// and the user read-only shadows cycle/instret).
// Read data, availability and the write-lookahead value are combinational.
// Counters advance every clock; WB-stage writes take precedence over increments.
// Optional feature: define CSR_HPM3_EN to add mhpmcounter3 (B03/B83, shadows
// C03/C83), the hpm3_event input and a writable mcountinhibit[3].
module csr_cntr_file #(
    parameter int         RSZ         = 32,
    parameter logic [2:0] INHIBIT_RST = 3'b000
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic [11:0]     csr_rd_addr,
    output logic [RSZ-1:0]  csr_rd_data,
    output logic            csr_avail,
    input  logic            nxt_csr_wr,
    input  logic [11:0]     nxt_csr_wr_addr,
    input  logic [RSZ-1:0]  nxt_csr_wr_data,
    output logic [RSZ-1:0]  nxt_csr_rd_data,
    input  logic            csr_wr,
    input  logic [11:0]     csr_wr_addr,
    input  logic [RSZ-1:0]  csr_wr_data,
`ifdef CSR_HPM3_EN
    input  logic            hpm3_event,
`endif
    input  logic            retire
);

    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MCNTINH   = 12'h320;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
`ifdef CSR_HPM3_EN
    localparam logic [11:0] A_MHPM3     = 12'hB03;
    localparam logic [11:0] A_MHPM3H    = 12'hB83;
    localparam logic [11:0] A_HPM3      = 12'hC03;
    localparam logic [11:0] A_HPM3H     = 12'hC83;
    localparam logic [3:0]  INH_WMASK   = 4'b1101;
`else
    localparam logic [3:0]  INH_WMASK   = 4'b0101;
`endif

    // Bit 1 (time) is never implemented, so it is cleared even in the reset value.
    localparam logic [3:0]  INH_RST_VAL = {1'b0, INHIBIT_RST[2], 1'b0, INHIBIT_RST[0]};
    localparam int          CW          = 2 * RSZ;

    logic [CW-1:0] mcycle_q,   mcycle_d;
    logic [CW-1:0] minstret_q, minstret_d;
    logic [3:0]    inhibit_q,  inhibit_d;
`ifdef CSR_HPM3_EN
    logic [CW-1:0] hpm3_q,     hpm3_d;
`endif

    // Counter update: a write to either half replaces that half from the old
    // value and suppresses the increment; otherwise count by 'inc' with 2*RSZ wrap.
    function automatic logic [CW-1:0] cntr_next(input logic [CW-1:0]  old,
                                                input logic           inc,
                                                input logic           wr_lo,
                                                input logic           wr_hi,
                                                input logic [RSZ-1:0] data);
        logic [CW-1:0] r;
        r = old + {{(CW-1){1'b0}}, inc};
        if (wr_lo) begin
            r = {old[CW-1:RSZ], data};
        end else if (wr_hi) begin
            r = {data, old[RSZ-1:0]};
        end
        return r;
    endfunction

    // Read mux shared by the EXE port and the lookahead path; unmapped addresses return zero.
    function automatic logic [RSZ-1:0] cur_value(input logic [11:0] a);
        logic [RSZ-1:0] v;
        v = '0;
        case (a)
            A_MCYCLE,   A_CYCLE:    v = mcycle_q[RSZ-1:0];
            A_MCYCLEH,  A_CYCLEH:   v = mcycle_q[CW-1:RSZ];
            A_MINSTRET, A_INSTRET:  v = minstret_q[RSZ-1:0];
            A_MINSTRETH, A_INSTRETH: v = minstret_q[CW-1:RSZ];
            A_MCNTINH:              v = {{(RSZ-4){1'b0}}, inhibit_q};
`ifdef CSR_HPM3_EN
            A_MHPM3,    A_HPM3:     v = hpm3_q[RSZ-1:0];
            A_MHPM3H,   A_HPM3H:    v = hpm3_q[CW-1:RSZ];
`endif
            default:                v = '0;
        endcase
        return v;
    endfunction

    function automatic logic is_impl(input logic [11:0] a);
        logic r;
        r = 1'b0;
        case (a)
            A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH, A_MCNTINH,
            A_CYCLE, A_CYCLEH, A_INSTRET, A_INSTRETH:   r = 1'b1;
`ifdef CSR_HPM3_EN
            A_MHPM3, A_MHPM3H, A_HPM3, A_HPM3H:         r = 1'b1;
`endif
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    // Only the machine-mode (Bxx and 320) addresses accept writes.
    function automatic logic is_writable(input logic [11:0] a);
        logic r;
        r = 1'b0;
        case (a)
            A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH, A_MCNTINH: r = 1'b1;
`ifdef CSR_HPM3_EN
            A_MHPM3, A_MHPM3H:                                       r = 1'b1;
`endif
            default:                                                 r = 1'b0;
        endcase
        return r;
    endfunction

    // EXE-side read port: pre-write contents, no forwarding of same-cycle writes.
    always_comb begin
        csr_rd_data = cur_value(csr_rd_addr);
        csr_avail   = is_impl(csr_rd_addr);
    end

    // Lookahead: value the addressed CSR will hold once the pending write lands.
    always_comb begin
        nxt_csr_rd_data = cur_value(nxt_csr_wr_addr);
        if (nxt_csr_wr && is_writable(nxt_csr_wr_addr)) begin
            if (nxt_csr_wr_addr == A_MCNTINH) begin
                nxt_csr_rd_data = nxt_csr_wr_data & {{(RSZ-4){1'b0}}, INH_WMASK};
            end else begin
                nxt_csr_rd_data = nxt_csr_wr_data;
            end
        end
    end

    // Next-state for all counters; the increment enables use the inhibit value
    // held this clock, so an inhibit write only affects later clocks.
    always_comb begin
        mcycle_d   = cntr_next(mcycle_q, ~inhibit_q[0],
                               csr_wr && (csr_wr_addr == A_MCYCLE),
                               csr_wr && (csr_wr_addr == A_MCYCLEH), csr_wr_data);
        minstret_d = cntr_next(minstret_q, retire & ~inhibit_q[2],
                               csr_wr && (csr_wr_addr == A_MINSTRET),
                               csr_wr && (csr_wr_addr == A_MINSTRETH), csr_wr_data);
`ifdef CSR_HPM3_EN
        hpm3_d     = cntr_next(hpm3_q, hpm3_event & ~inhibit_q[3],
                               csr_wr && (csr_wr_addr == A_MHPM3),
                               csr_wr && (csr_wr_addr == A_MHPM3H), csr_wr_data);
`endif
        inhibit_d  = inhibit_q;
        if (csr_wr && (csr_wr_addr == A_MCNTINH)) begin
            inhibit_d = csr_wr_data[3:0] & INH_WMASK;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            inhibit_q  <= INH_RST_VAL;
`ifdef CSR_HPM3_EN
            hpm3_q     <= '0;
`endif
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            inhibit_q  <= inhibit_d;
`ifdef CSR_HPM3_EN
            hpm3_q     <= hpm3_d;
`endif
        end
    end

endmodule

// File: tb/tb_csr_cntr_file.sv
// tb_csr_cntr_file: scoreboard bench for csr_cntr_file. Expected values are
// queued as stimulus is applied and compared against the combinational outputs
// one entry at a time, with one line printed per comparison.
module tb_csr_cntr_file;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [11:0] csr_rd_addr = '0;
    logic [31:0] csr_rd_data;
    logic        csr_avail;
    logic        nxt_csr_wr = 1'b0;
    logic [11:0] nxt_csr_wr_addr = '0;
    logic [31:0] nxt_csr_wr_data = '0;
    logic [31:0] nxt_csr_rd_data;
    logic        csr_wr = 1'b0;
    logic [11:0] csr_wr_addr = '0;
    logic [31:0] csr_wr_data = '0;
    logic        retire = 1'b0;
`ifdef CSR_HPM3_EN
    logic        hpm3_event = 1'b0;
    localparam logic [31:0] INH_ALL   = 32'hD;
    localparam logic [31:0] HPM3_EXP  = 32'h77;
    localparam logic        HPM3_AV   = 1'b1;
`else
    localparam logic [31:0] INH_ALL   = 32'h5;
    localparam logic [31:0] HPM3_EXP  = 32'h0;
    localparam logic        HPM3_AV   = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          kind;     // 0 read data, 1 avail, 2 lookahead
        logic [11:0] addr;
        logic        nv;
        logic [31:0] nd;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    csr_cntr_file dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .csr_rd_addr     (csr_rd_addr),
        .csr_rd_data     (csr_rd_data),
        .csr_avail       (csr_avail),
        .nxt_csr_wr      (nxt_csr_wr),
        .nxt_csr_wr_addr (nxt_csr_wr_addr),
        .nxt_csr_wr_data (nxt_csr_wr_data),
        .nxt_csr_rd_data (nxt_csr_rd_data),
        .csr_wr          (csr_wr),
        .csr_wr_addr     (csr_wr_addr),
        .csr_wr_data     (csr_wr_data),
`ifdef CSR_HPM3_EN
        .hpm3_event      (hpm3_event),
`endif
        .retire          (retire)
    );

    always #10 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic push_rd(input string tag, input logic [11:0] a, input logic [31:0] e);
        sb_t s;
        s.tag = tag; s.kind = 0; s.addr = a; s.nv = 1'b0; s.nd = '0; s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic push_av(input string tag, input logic [11:0] a, input logic e);
        sb_t s;
        s.tag = tag; s.kind = 1; s.addr = a; s.nv = 1'b0; s.nd = '0; s.exp = {31'b0, e};
        sb_q.push_back(s);
    endtask

    task automatic push_nxt(input string tag, input logic [11:0] a, input logic v,
                            input logic [31:0] d, input logic [31:0] e);
        sb_t s;
        s.tag = tag; s.kind = 2; s.addr = a; s.nv = v; s.nd = d; s.exp = e;
        sb_q.push_back(s);
    endtask

    // Pop every queued expectation and compare it against the live outputs.
    task automatic drain();
        sb_t s;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            case (s.kind)
                0: begin csr_rd_addr = s.addr; #1; check_eq(s.tag, csr_rd_data, s.exp); end
                1: begin csr_rd_addr = s.addr; #1; check_eq(s.tag, {31'b0, csr_avail}, s.exp); end
                default: begin
                    nxt_csr_wr = s.nv; nxt_csr_wr_addr = s.addr; nxt_csr_wr_data = s.nd;
                    #1; check_eq(s.tag, nxt_csr_rd_data, s.exp);
                end
            endcase
        end
        nxt_csr_wr = 1'b0;
    endtask

    // One clock: inputs set beforehand are sampled on this edge, then cleared.
    task automatic tick();
        @(posedge clk_in);
        #1;
        csr_wr = 1'b0;
        retire = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wr = 1'b1; csr_wr_addr = a; csr_wr_data = d;
    endtask

    initial begin
        #1;
        push_rd("rst_b00", 12'hB00, 32'h0);
        push_rd("rst_b80", 12'hB80, 32'h0);
        push_rd("rst_b02", 12'hB02, 32'h0);
        push_rd("rst_320", 12'h320, 32'h0);
        push_av("rst_av_b00", 12'hB00, 1'b1);
        drain();

        // Free run 10 clocks after release.
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (10) tick();
        push_rd("run10_b00", 12'hB00, 32'd10);
        push_rd("run10_c00", 12'hC00, 32'd10);
        push_rd("run10_b80", 12'hB80, 32'd0);
        drain();

        // minstret: 3 retires, then write racing a retire.
        repeat (3) begin retire = 1'b1; tick(); end
        push_rd("ret3_b02", 12'hB02, 32'd3);
        push_rd("ret3_c02", 12'hC02, 32'd3);
        drain();
        retire = 1'b1;
        wr(12'hB02, 32'h100);
        tick();
        push_rd("wr_vs_ret_b02", 12'hB02, 32'h100);
        drain();
        tick();
        push_rd("idle_b02", 12'hB02, 32'h100);
        push_rd("idle_b82", 12'hB82, 32'h0);
        drain();

        // 64-bit wrap through both halves.
        wr(12'hB00, 32'hFFFF_FFFE); tick();
        wr(12'hB80, 32'hFFFF_FFFF); tick();
        push_rd("pre_wrap_b00", 12'hB00, 32'hFFFF_FFFE);
        push_rd("pre_wrap_b80", 12'hB80, 32'hFFFF_FFFF);
        drain();
        repeat (3) tick();
        push_rd("wrap_b00", 12'hB00, 32'h1);
        push_rd("wrap_b80", 12'hB80, 32'h0);
        push_rd("wrap_c80", 12'hC80, 32'h0);
        push_nxt("nxt_b00_wr", 12'hB00, 1'b1, 32'h0000_ABCD, 32'h0000_ABCD);
        push_nxt("nxt_b00_nowr", 12'hB00, 1'b0, 32'h0000_ABCD, 32'h1);
        push_nxt("nxt_c00_ro", 12'hC00, 1'b1, 32'h1234, 32'h1);
        push_nxt("nxt_7ff", 12'h7FF, 1'b1, 32'h1234, 32'h0);
        drain();

        // Inhibit: writing clock still counts, later clocks frozen.
        wr(12'h320, 32'hFFFF_FFFF); tick();
        push_rd("inh_320", 12'h320, INH_ALL);
        push_rd("inh_b00", 12'hB00, 32'h2);
        drain();
        repeat (3) begin retire = 1'b1; tick(); end
        push_rd("frozen_b00", 12'hB00, 32'h2);
        push_rd("frozen_b02", 12'hB02, 32'h100);
        push_nxt("nxt_320_wr", 12'h320, 1'b1, 32'hFFFF_FFFF, INH_ALL);
        push_nxt("nxt_320_nowr", 12'h320, 1'b0, 32'h0, INH_ALL);
        drain();
        wr(12'h320, 32'h0); tick();
        push_rd("uninh_b00", 12'hB00, 32'h2);
        push_rd("uninh_320", 12'h320, 32'h0);
        drain();
        repeat (2) tick();
        push_rd("resume_b00", 12'hB00, 32'h4);
        drain();

        // Read-only shadow and unimplemented addresses ignore writes.
        wr(12'hC00, 32'h1234); tick();
        push_rd("ro_wr_b00", 12'hB00, 32'h5);
        push_rd("ro_wr_c00", 12'hC00, 32'h5);
        push_av("av_c00", 12'hC00, 1'b1);
        push_av("av_7ff", 12'h7FF, 1'b0);
        push_rd("rd_7ff", 12'h7FF, 32'h0);
        drain();
        wr(12'hB03, 32'h77); tick();
        push_rd("hpm3_b03", 12'hB03, HPM3_EXP);
        push_av("av_b03", 12'hB03, HPM3_AV);
        push_rd("hpm3_b00", 12'hB00, 32'h6);
        drain();

        // Asynchronous reset between edges.
        retire = 1'b1; tick();
        #4;
        reset_in = 1'b0;
        #1;
        push_rd("arst_b00", 12'hB00, 32'h0);
        push_rd("arst_c00", 12'hC00, 32'h0);
        push_rd("arst_b02", 12'hB02, 32'h0);
        push_rd("arst_320", 12'h320, 32'h0);
        push_rd("arst_b03", 12'hB03, 32'h0);
        drain();
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (2) tick();
        push_rd("rerun_b00", 12'hB00, 32'h2);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
